// File: rtl/skein_search_controller.sv
// Brute-force Skein-1024 search sequencer: walks a counter through candidate blocks,
// launches the hash core per candidate and tracks the lowest Hamming distance seen.
module skein_search_controller #(
  parameter int unsigned CTR_W   = 64,
  parameter int unsigned DIST_W  = 11,
  parameter int unsigned STATE_W = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [CTR_W-1:0]   seed_i,
  input  logic [DIST_W-1:0]  target_i,
  output logic               zero_o,
  output logic               write_o,
  output logic [STATE_W-1:0] state_o,
  output logic               hash_start_o,
  input  logic               hash_done_i,
  input  logic [DIST_W-1:0]  dist_i,
  output logic               busy_o,
  output logic               found_o,
  output logic               best_valid_o,
  output logic [DIST_W-1:0]  best_dist_o,
  output logic [CTR_W-1:0]   best_ctr_o,
  output logic [CTR_W-1:0]   attempts_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_HASH  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t              r_state;
  logic [CTR_W-1:0]    r_ctr;
  logic [DIST_W-1:0]   r_target;
  logic                r_stop_pending;
  logic                r_zero;
  logic                r_write;
  logic                r_hash_start;
  logic                r_busy;
  logic                r_found;
  logic                r_best_valid;
  logic [STATE_W-1:0]  r_state_out;
  logic [DIST_W-1:0]   r_best_dist;
  logic [CTR_W-1:0]    r_best_ctr;
  logic [CTR_W-1:0]    r_attempts;

  logic                w_better;
  logic                w_hit;
  logic                w_stop;
  logic                w_ctr_last;
  logic [CTR_W-1:0]    w_ctr_next;

  assign w_better   = (dist_i < r_best_dist);
  assign w_hit      = (dist_i <= r_target);
  assign w_stop     = r_stop_pending | stop_i;
  assign w_ctr_last = (r_ctr == {CTR_W{1'b1}});
  assign w_ctr_next = r_ctr + CTR_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= S_IDLE;
      r_ctr          <= '0;
      r_target       <= '0;
      r_stop_pending <= 1'b0;
      r_zero         <= 1'b0;
      r_write        <= 1'b0;
      r_hash_start   <= 1'b0;
      r_busy         <= 1'b0;
      r_found        <= 1'b0;
      r_best_valid   <= 1'b0;
      r_state_out    <= '0;
      r_best_dist    <= '1;
      r_best_ctr     <= '0;
      r_attempts     <= '0;
    end else begin
      r_zero       <= 1'b0;
      r_write      <= 1'b0;
      r_hash_start <= 1'b0;
      if (r_state != S_IDLE && stop_i) r_stop_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_ctr          <= seed_i;
            r_target       <= target_i;
            r_best_dist    <= '1;
            r_best_valid   <= 1'b0;
            r_found        <= 1'b0;
            r_attempts     <= '0;
            r_stop_pending <= 1'b0;
            r_zero         <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_write     <= 1'b1;
          r_state_out <= STATE_W'(r_ctr);
          r_state     <= S_LOAD;
        end
        S_LOAD: begin
          r_hash_start <= 1'b1;
          r_state      <= S_HASH;
        end
        S_HASH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (hash_done_i) begin
            r_attempts   <= r_attempts + CTR_W'(1);
            r_best_valid <= 1'b1;
            // Strict compare: an equal distance keeps the earlier counter.
            if (w_better) begin
              r_best_dist <= dist_i;
              r_best_ctr  <= r_ctr;
            end
            if (w_hit) begin
              r_found <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else if (w_stop) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else if (w_ctr_last) begin
              r_ctr   <= '0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_ctr       <= w_ctr_next;
              r_write     <= 1'b1;
              r_state_out <= STATE_W'(w_ctr_next);
              r_state     <= S_LOAD;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign zero_o       = r_zero;
  assign write_o      = r_write;
  assign state_o      = r_state_out;
  assign hash_start_o = r_hash_start;
  assign busy_o       = r_busy;
  assign found_o      = r_found;
  assign best_valid_o = r_best_valid;
  assign best_dist_o  = r_best_dist;
  assign best_ctr_o   = r_best_ctr;
  assign attempts_o   = r_attempts;

endmodule

// File: tb/tb_skein_search_controller.sv
// Self-checking bench for skein_search_controller: a behavioural hash-core model answers
// launches with queued distances, and each run is compared against a search-loop reference.
module tb_skein_search_controller;

  localparam int unsigned CTR_W   = 64;
  localparam int unsigned DIST_W  = 11;
  localparam int unsigned STATE_W = 1024;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               start_i;
  logic               stop_i;
  logic [CTR_W-1:0]   seed_i;
  logic [DIST_W-1:0]  target_i;
  logic               zero_o;
  logic               write_o;
  logic [STATE_W-1:0] state_o;
  logic               hash_start_o;
  logic               busy_o;
  logic               found_o;
  logic               best_valid_o;
  logic [DIST_W-1:0]  best_dist_o;
  logic [CTR_W-1:0]   best_ctr_o;
  logic [CTR_W-1:0]   attempts_o;

  logic               hm_done = 1'b0;
  logic [DIST_W-1:0]  hm_dist = '0;
  logic               tb_done = 1'b0;
  logic [DIST_W-1:0]  tb_dist = '0;
  wire                hash_done_i = hm_done | tb_done;
  wire  [DIST_W-1:0]  dist_i = tb_done ? tb_dist : hm_dist;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor + hash-core model state (written only by the negedge process)
  int n_zero = 0, n_write = 0, n_hs = 0, n_overlap = 0, n_upper = 0;
  int hm_cnt = 0, hm_k = 0;
  logic [CTR_W-1:0] wq[$];
  // Written only by the stimulus tasks
  logic [DIST_W-1:0] dq[$];
  int hs_base = 0;
  int hm_lat  = 4;

  skein_search_controller #(.CTR_W(CTR_W), .DIST_W(DIST_W), .STATE_W(STATE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .seed_i(seed_i), .target_i(target_i), .zero_o(zero_o), .write_o(write_o),
    .state_o(state_o), .hash_start_o(hash_start_o), .hash_done_i(hash_done_i),
    .dist_i(dist_i), .busy_o(busy_o), .found_o(found_o), .best_valid_o(best_valid_o),
    .best_dist_o(best_dist_o), .best_ctr_o(best_ctr_o), .attempts_o(attempts_o)
  );

  always #5 clk_i = ~clk_i;

  // Strobe monitor and hash core: done arrives hm_lat cycles after each launch
  always @(negedge clk_i) begin
    hm_done = 1'b0;
    if (hm_cnt > 0) begin
      hm_cnt--;
      if (hm_cnt == 0) begin
        hm_done = 1'b1;
        hm_dist = (hm_k >= 0 && hm_k < dq.size()) ? dq[hm_k] : DIST_W'(1000);
      end
    end
    if (int'(zero_o) + int'(write_o) + int'(hash_start_o) > 1) n_overlap++;
    if (zero_o) n_zero++;
    if (write_o) begin
      n_write++;
      wq.push_back(state_o[CTR_W-1:0]);
      if (state_o[STATE_W-1:CTR_W] != '0) n_upper++;
    end
    if (hash_start_o) begin
      n_hs++;
      hm_cnt = hm_lat;
      hm_k   = n_hs - 1 - hs_base;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives one search over dq and checks it against the reference search loop.
  task automatic run_search(input logic [CTR_W-1:0] seed, input logic [DIST_W-1:0] tgt,
                            input int lat, input int stop_idx, input logic poke_start,
                            input string name);
    logic [DIST_W-1:0] e_best = '1;
    logic [CTR_W-1:0]  e_bctr = '0;
    logic [CTR_W-1:0]  cand;
    logic [CTR_W-1:0]  e_cands[$];
    int  e_att = 0;
    logic e_found = 1'b0;
    int  z0, w0, ov0, up0, cyc;
    logic stopped = 1'b0;
    logic done_ok = 1'b0;

    for (int i = 0; i < dq.size(); i++) begin
      cand = seed + CTR_W'(i);
      e_cands.push_back(cand);
      e_att++;
      if (dq[i] < e_best) begin
        e_best = dq[i];
        e_bctr = cand;
      end
      if (dq[i] <= tgt) begin
        e_found = 1'b1;
        break;
      end
      if (i == stop_idx) break;
      if (cand == {CTR_W{1'b1}}) break;
    end

    hs_base = n_hs;
    hm_lat  = lat;
    z0 = n_zero; w0 = wq.size(); ov0 = n_overlap; up0 = n_upper;
    seed_i = seed; target_i = tgt; start_i = 1'b1;
    tick();
    start_i = 1'b0; seed_i = ~seed; target_i = ~tgt;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (!busy_o) begin
        done_ok = 1'b1;
        break;
      end
      stop_i = 1'b0;
      if (!stopped && stop_idx >= 0 && (n_hs - hs_base) == stop_idx + 1) begin
        stop_i = 1'b1;
        stopped = 1'b1;
      end
      start_i = poke_start && (cyc == 3);
      tick();
    end
    stop_i = 1'b0; start_i = 1'b0;

    n_tests++;
    if (!done_ok) begin
      n_fail++;
      $display("FAIL %s timeout: busy_o still %0b after 3000 cycles, required 0", name, busy_o);
      return;
    end
    n_tests++;
    if (best_dist_o !== e_best) begin
      n_fail++; $display("FAIL %s best_dist: got %0d, expected %0d", name, best_dist_o, e_best);
    end
    n_tests++;
    if (best_ctr_o !== e_bctr) begin
      n_fail++; $display("FAIL %s best_ctr: got %h, expected %h", name, best_ctr_o, e_bctr);
    end
    n_tests++;
    if (attempts_o !== CTR_W'(e_att)) begin
      n_fail++; $display("FAIL %s attempts: got %0d, expected %0d", name, attempts_o, e_att);
    end
    n_tests++;
    if (found_o !== e_found || best_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s found/valid: got %0b/%0b, expected %0b/1", name, found_o, best_valid_o, e_found);
    end
    n_tests++;
    if (n_zero - z0 != 1 || n_hs - hs_base != e_att || wq.size() - w0 != e_cands.size()) begin
      n_fail++;
      $display("FAIL %s strobe counts: zero %0d hash %0d write %0d, expected 1 %0d %0d",
               name, n_zero - z0, n_hs - hs_base, wq.size() - w0, e_att, e_cands.size());
    end else begin
      for (int i = 0; i < e_cands.size(); i++) begin
        n_tests++;
        if (wq[w0 + i] !== e_cands[i]) begin
          n_fail++; $display("FAIL %s candidate %0d: got %h, expected %h", name, i, wq[w0 + i], e_cands[i]);
        end
      end
    end
    n_tests++;
    if (n_overlap != ov0 || n_upper != up0) begin
      n_fail++;
      $display("FAIL %s overlap/upper bits: got %0d/%0d, expected 0/0", name, n_overlap - ov0, n_upper - up0);
    end
  endtask

  task automatic check_idle_quiet(input int cycles, input string name);
    int s0 = n_zero + n_write + n_hs;
    logic busy_seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (busy_o) busy_seen = 1'b1;
    end
    n_tests++;
    if (busy_seen || n_zero + n_write + n_hs != s0) begin
      n_fail++;
      $display("FAIL %s quiet: busy seen %0b, strobes %0d, expected 0 and 0", name, busy_seen, n_zero + n_write + n_hs - s0);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; seed_i = '0; target_i = '0;
    #12;
    n_tests++;
    if (busy_o !== 1'b0 || found_o !== 1'b0 || best_valid_o !== 1'b0 || best_dist_o !== 11'h7FF ||
        best_ctr_o !== '0 || attempts_o !== '0 || state_o !== '0 ||
        zero_o !== 1'b0 || write_o !== 1'b0 || hash_start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset values: busy %0b found %0b valid %0b best %h ctr %h att %0d, expected 0 0 0 7ff 0 0",
               busy_o, found_o, best_valid_o, best_dist_o, best_ctr_o, attempts_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    check_idle_quiet(20, "reset_idle");
    n_tests++;
    if (best_dist_o !== 11'h7FF) begin
      n_fail++; $display("FAIL reset_idle best_dist: got %h, expected 7ff", best_dist_o);
    end
  endtask

  task automatic test_single_run();
    dq = '{11'd600, 11'd520, 11'd530};
    run_search(64'd5, 11'd0, 4, 2, 1'b0, "single_run");
  endtask

  task automatic test_early_exit();
    dq = '{11'd500, 11'd399, 11'd10, 11'd10};
    run_search(64'd0, 11'd400, 4, -1, 1'b0, "early_exit");
  endtask

  task automatic test_stop();
    dq = '{11'd800, 11'd100, 11'd50};
    run_search({$urandom, $urandom}, 11'd0, 5, 0, 1'b0, "stop_mid_hash");
    check_idle_quiet(10, "stop_after");
  endtask

  task automatic test_wrap();
    dq = '{11'd700, 11'd1, 11'd1};
    run_search({CTR_W{1'b1}}, 11'd0, 3, -1, 1'b0, "counter_wrap");
    dq = '{11'd300, 11'd300, 11'd400};
    run_search(64'd100, 11'd0, 2, 2, 1'b0, "tie_keeps_first");
    dq = '{11'd900, 11'd800, 11'd700, 11'd5};
    run_search({CTR_W{1'b1}} - 64'd1, 11'd0, 1, -1, 1'b0, "near_wrap");
  endtask

  task automatic test_ignored_inputs();
    logic [CTR_W-1:0] att0;
    logic [DIST_W-1:0] bd0;
    dq = '{11'd600, 11'd650, 11'd610, 11'd20};
    run_search(64'h1234, 11'd30, 3, -1, 1'b1, "start_while_busy");
    att0 = attempts_o; bd0 = best_dist_o;
    tb_dist = 11'd0; tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    tick();
    n_tests++;
    if (attempts_o !== att0 || best_dist_o !== bd0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL done_in_idle: att %0d best %0d busy %0b, expected %0d %0d 0", attempts_o, best_dist_o, busy_o, att0, bd0);
    end
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    dq = '{11'd900, 11'd901, 11'd3};
    run_search(64'h77, 11'd3, 2, -1, 1'b0, "stop_in_idle");
  endtask

  task automatic test_random();
    int n, stop_idx;
    logic [DIST_W-1:0] tgt;
    logic [CTR_W-1:0] seed;
    for (int r = 0; r < 24; r++) begin
      n   = $urandom_range(1, 8);
      tgt = DIST_W'($urandom_range(0, 300));
      dq  = {};
      for (int i = 0; i < n; i++) dq.push_back(DIST_W'($urandom_range(0, 1024)));
      if ($urandom_range(0, 1) == 1) begin
        stop_idx = -1;
        dq[n-1]  = DIST_W'($urandom_range(0, int'(tgt)));
      end else begin
        stop_idx = $urandom_range(0, n - 1);
      end
      seed = ($urandom_range(0, 3) == 0) ? ({CTR_W{1'b1}} - CTR_W'($urandom_range(0, 4)))
                                         : {$urandom, $urandom};
      run_search(seed, tgt, $urandom_range(1, 6), stop_idx, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_in_wait();
    int s0, cyc;
    dq = '{11'd5};
    hs_base = n_hs;
    hm_lat  = 25;
    seed_i = 64'hABCD; target_i = 11'd100; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (cyc = 0; cyc < 50 && (n_hs - hs_base) < 1; cyc++) tick();
    tick(); tick(); tick();
    n_tests++;
    if (busy_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_wait precondition: busy %0b, expected 1", busy_o);
    end
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || best_dist_o !== 11'h7FF || attempts_o !== '0 || state_o !== '0 ||
        best_valid_o !== 1'b0 || found_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_wait async: busy %0b best %h att %0d valid %0b, expected 0 7ff 0 0",
               busy_o, best_dist_o, attempts_o, best_valid_o);
    end
    tick();
    rst_i = 1'b0;
    s0 = n_zero + n_write + n_hs;
    for (int i = 0; i < 30; i++) tick();
    tb_dist = 11'd1; tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    tick();
    n_tests++;
    if (attempts_o !== '0 || best_valid_o !== 1'b0 || best_dist_o !== 11'h7FF || busy_o !== 1'b0 ||
        n_zero + n_write + n_hs != s0) begin
      n_fail++;
      $display("FAIL reset_in_wait spurious done: att %0d valid %0b best %h strobes %0d, expected 0 0 7ff 0",
               attempts_o, best_valid_o, best_dist_o, n_zero + n_write + n_hs - s0);
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_early_exit();
    test_stop();
    test_wrap();
    test_ignored_inputs();
    test_random();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
